// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounces the mode/inc/dec buttons,
// walks through hour/minute/second edit modes on editable shadow copies of
// the time, and issues a single-cycle load strobe to all three counters on
// commit. Counting is gated off whenever an edit is in progress.
module time_set_ctrl #(
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] s_hour,
    output logic [7:0] s_min,
    output logic [7:0] s_sec,
    output logic       set_hour,
    output logic       set_min,
    output logic       set_sec,
    output logic       run_ena,
    output logic [1:0] edit_field
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 32'd1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1'b1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);
    localparam logic [7:0]    HOUR_MAX = 8'd23;
    localparam logic [7:0]    MS_MAX   = 8'd59;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Increment with wrap from the field maximum back to zero.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v >= max_v) ? 8'd0 : (v + 8'd1);
    endfunction

    // Decrement with wrap from zero up to the field maximum.
    function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max_v);
        return (v == 8'd0) ? max_v : (v - 8'd1);
    endfunction

    // Out-of-range live values are loaded as zero so the shadow is always legal.
    function automatic logic [7:0] clamp_cap(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? 8'd0 : v;
    endfunction

    // Key vector order: bit 0 = mode, bit 1 = inc, bit 2 = dec.
    logic [2:0]    key_raw_s;
    logic [2:0]    sync1_r, sync2_r, deb_r, press_r;
    logic [DW-1:0] deb_cnt_r [3];

    assign key_raw_s = {key_dec_n, key_inc_n, key_mode_n};

    // Two-flop synchronizer, debounce counter and press-edge pulse per key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
            deb_r   <= 3'b111;
            press_r <= 3'b000;
            for (int k = 0; k < 3; k++) deb_cnt_r[k] <= {DW{1'b0}};
        end else begin
            sync1_r <= key_raw_s;
            sync2_r <= sync1_r;
            for (int k = 0; k < 3; k++) begin
                if (sync2_r[k] == deb_r[k]) begin
                    deb_cnt_r[k] <= {DW{1'b0}};
                    press_r[k]   <= 1'b0;
                end else if (deb_cnt_r[k] == DEB_LAST) begin
                    deb_r[k]     <= sync2_r[k];
                    deb_cnt_r[k] <= {DW{1'b0}};
                    press_r[k]   <= ~sync2_r[k];
                end else begin
                    deb_cnt_r[k] <= deb_cnt_r[k] + DEB_ONE;
                    press_r[k]   <= 1'b0;
                end
            end
        end
    end

    state_t        state_r, state_nxt_s;
    logic [TW-1:0] tmo_r, tmo_nxt_s;
    logic [7:0]    s_hour_r, s_min_r, s_sec_r;
    logic [7:0]    hour_nxt_s, min_nxt_s, sec_nxt_s;
    logic          set_r, set_nxt_s, run_ena_r, run_ena_nxt_s;
    logic [1:0]    field_r, field_nxt_s;
    logic          mode_p_s, inc_p_s, dec_p_s;

    assign mode_p_s = press_r[0];
    assign inc_p_s  = press_r[1];
    assign dec_p_s  = press_r[2];

    // Next-state, timeout, shadow arithmetic and next output values.
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_r;
        hour_nxt_s  = s_hour_r;
        min_nxt_s   = s_min_r;
        sec_nxt_s   = s_sec_r;
        case (state_r)
            ST_RUN: begin
                tmo_nxt_s = {TW{1'b0}};
                if (mode_p_s) begin
                    hour_nxt_s  = clamp_cap(cur_hour, HOUR_MAX);
                    min_nxt_s   = clamp_cap(cur_min, MS_MAX);
                    sec_nxt_s   = clamp_cap(cur_sec, MS_MAX);
                    state_nxt_s = ST_EDIT_H;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (mode_p_s || inc_p_s || dec_p_s) begin
                    tmo_nxt_s = {TW{1'b0}};
                end else if (tmo_r == TMO_LAST) begin
                    tmo_nxt_s   = {TW{1'b0}};
                    state_nxt_s = ST_RUN;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_ONE;
                end
                // Mode has priority; inc together with dec cancels out.
                if (mode_p_s) begin
                    case (state_r)
                        ST_EDIT_H: state_nxt_s = ST_EDIT_M;
                        ST_EDIT_M: state_nxt_s = ST_EDIT_S;
                        default:   state_nxt_s = ST_COMMIT;
                    endcase
                end else if (inc_p_s && !dec_p_s) begin
                    case (state_r)
                        ST_EDIT_H: hour_nxt_s = wrap_inc(s_hour_r, HOUR_MAX);
                        ST_EDIT_M: min_nxt_s  = wrap_inc(s_min_r, MS_MAX);
                        default:   sec_nxt_s  = wrap_inc(s_sec_r, MS_MAX);
                    endcase
                end else if (dec_p_s && !inc_p_s) begin
                    case (state_r)
                        ST_EDIT_H: hour_nxt_s = wrap_dec(s_hour_r, HOUR_MAX);
                        ST_EDIT_M: min_nxt_s  = wrap_dec(s_min_r, MS_MAX);
                        default:   sec_nxt_s  = wrap_dec(s_sec_r, MS_MAX);
                    endcase
                end else begin
                    hour_nxt_s = s_hour_r;
                end
            end
            ST_COMMIT: begin
                tmo_nxt_s   = {TW{1'b0}};
                state_nxt_s = ST_RUN;
            end
            default: begin
                tmo_nxt_s   = {TW{1'b0}};
                state_nxt_s = ST_RUN;
            end
        endcase

        set_nxt_s     = (state_nxt_s == ST_COMMIT);
        run_ena_nxt_s = (state_nxt_s == ST_RUN);
        case (state_nxt_s)
            ST_EDIT_H: field_nxt_s = 2'd1;
            ST_EDIT_M: field_nxt_s = 2'd2;
            ST_EDIT_S: field_nxt_s = 2'd3;
            default:   field_nxt_s = 2'd0;
        endcase
    end

    // State, timeout counter, shadows and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            tmo_r     <= {TW{1'b0}};
            s_hour_r  <= 8'd0;
            s_min_r   <= 8'd0;
            s_sec_r   <= 8'd0;
            set_r     <= 1'b0;
            run_ena_r <= 1'b1;
            field_r   <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            tmo_r     <= tmo_nxt_s;
            s_hour_r  <= hour_nxt_s;
            s_min_r   <= min_nxt_s;
            s_sec_r   <= sec_nxt_s;
            set_r     <= set_nxt_s;
            run_ena_r <= run_ena_nxt_s;
            field_r   <= field_nxt_s;
        end
    end

    assign s_hour     = s_hour_r;
    assign s_min      = s_min_r;
    assign s_sec      = s_sec_r;
    assign set_hour   = set_r;
    assign set_min    = set_r;
    assign set_sec    = set_r;
    assign run_ena    = run_ena_r;
    assign edit_field = field_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce and timeout settings.
module tb_time_set_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_mode_n = 1'b1, key_inc_n = 1'b1, key_dec_n = 1'b1;
    logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
    logic [7:0] s_hour, s_min, s_sec;
    logic       set_hour, set_min, set_sec, run_ena;
    logic [1:0] edit_field;

    int checks = 0;
    int failures = 0;
    int npulse, pulse_k, setcnt;
    logic [7:0] ph, pm, ps;
    logic       p_run, a_run;
    logic [1:0] a_field;

    time_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .s_hour(s_hour), .s_min(s_min), .s_sec(s_sec),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .run_ena(run_ena), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the selected keys long enough to debounce, then release and settle.
    task automatic press(input logic m, input logic i, input logic d);
        @(negedge clk);
        key_mode_n = ~m; key_inc_n = ~i; key_dec_n = ~d;
        repeat (DEB + 4) @(negedge clk);
        key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
        repeat (DEB + 4) @(negedge clk);
    endtask

    // A low pulse lasting DEB-1 sampled cycles on one key.
    task automatic glitch(input logic m, input logic i);
        @(negedge clk);
        key_mode_n = ~m; key_inc_n = ~i;
        repeat (DEB - 1) @(negedge clk);
        key_mode_n = 1'b1; key_inc_n = 1'b1;
        repeat (DEB + 4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_field", edit_field, 2'd0);
        chk("rst_run", run_ena, 1'b1);
        chk("rst_set", {set_hour, set_min, set_sec}, 3'b000);
        chk("rst_shadow", {s_hour, s_min, s_sec}, 24'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Debounce: short mode glitch ignored; held mode enters EDIT_H at edge DEB+3
        glitch(1'b1, 1'b0);
        chk("glitch_mode_field", edit_field, 2'd0);
        cur_hour = 8'd23; cur_min = 8'd0; cur_sec = 8'd59;
        @(negedge clk);
        key_mode_n = 1'b0;
        repeat (DEB + 2) @(posedge clk);
        #1;
        chk("deb_early_field", edit_field, 2'd0);
        chk("deb_early_run", run_ena, 1'b1);
        @(posedge clk);
        #1;
        chk("deb_entry_field", edit_field, 2'd1);
        chk("deb_entry_run", run_ena, 1'b0);
        chk("capture", {s_hour, s_min, s_sec}, {8'd23, 8'd0, 8'd59});
        repeat (2) @(negedge clk);
        key_mode_n = 1'b1;
        repeat (DEB + 4) @(negedge clk);

        // Edit wrap
        glitch(1'b0, 1'b1);
        chk("glitch_inc", s_hour, 8'd23);
        press(1'b0, 1'b1, 1'b0);
        chk("hour_inc_wrap", s_hour, 8'd0);
        press(1'b0, 1'b0, 1'b1);
        chk("hour_dec_wrap", s_hour, 8'd23);
        press(1'b0, 1'b1, 1'b0);
        chk("hour_inc_wrap2", s_hour, 8'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("to_edit_m", edit_field, 2'd2);
        press(1'b0, 1'b0, 1'b1);
        chk("min_dec_wrap", s_min, 8'd59);
        press(1'b1, 1'b0, 1'b0);
        chk("to_edit_s", edit_field, 2'd3);
        press(1'b0, 1'b1, 1'b0);
        chk("sec_inc_wrap", s_sec, 8'd0);
        chk("hour_held", s_hour, 8'd0);

        // Commit: one strobe cycle, DEB+3 edges after mode goes low
        npulse = 0; pulse_k = -1; ph = 8'd0; pm = 8'd0; ps = 8'd0;
        p_run = 1'b1; a_run = 1'b0; a_field = 2'd3;
        @(negedge clk);
        key_mode_n = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 8) key_mode_n = 1'b1;
            if (pulse_k >= 0 && k == pulse_k + 1) begin
                a_run = run_ena; a_field = edit_field;
            end
            if (set_hour || set_min || set_sec) begin
                npulse++;
                if (set_hour && set_min && set_sec) pulse_k = k;
                ph = s_hour; pm = s_min; ps = s_sec; p_run = run_ena;
            end
        end
        repeat (DEB + 4) @(negedge clk);
        chk("commit_pulses", npulse, 1);
        chk("commit_when", pulse_k, DEB + 2);
        chk("commit_values", {ph, pm, ps}, {8'd0, 8'd59, 8'd0});
        chk("commit_run_low", p_run, 1'b0);
        chk("after_commit_run", a_run, 1'b1);
        chk("after_commit_field", a_field, 2'd0);

        // Timeout from EDIT_M after exactly TMO idle cycles
        press(1'b1, 1'b0, 1'b0);
        chk("tmo_edit_h", edit_field, 2'd1);
        setcnt = 0;
        @(negedge clk);
        key_mode_n = 1'b0;
        repeat (DEB + 3) @(posedge clk);
        #1;
        chk("tmo_edit_m", edit_field, 2'd2);
        for (int k = 1; k < TMO; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) key_mode_n = 1'b1;
            if (set_hour || set_min || set_sec) setcnt++;
        end
        chk("tmo_before", edit_field, 2'd2);
        @(posedge clk);
        #1;
        chk("tmo_field", edit_field, 2'd0);
        chk("tmo_run", run_ena, 1'b1);
        chk("tmo_no_set", setcnt + int'(set_hour), 0);
        repeat (4) @(negedge clk);

        // Simultaneous events and out-of-range capture
        cur_hour = 8'd5; cur_min = 8'd75; cur_sec = 8'd60;
        press(1'b1, 1'b0, 1'b0);
        chk("cap_clamp", {s_hour, s_min, s_sec}, {8'd5, 8'd0, 8'd0});
        press(1'b1, 1'b1, 1'b0);
        chk("mode_inc_field", edit_field, 2'd2);
        chk("mode_inc_hour", s_hour, 8'd5);
        press(1'b0, 1'b1, 1'b1);
        chk("inc_dec_min", s_min, 8'd0);
        chk("inc_dec_field", edit_field, 2'd2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("back_run", run_ena, 1'b1);

        // Asynchronous reset mid-edit, then RUN ignores inc/dec
        cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("pre_rst_field", edit_field, 2'd3);
        chk("pre_rst_shadow", {s_hour, s_min, s_sec}, {8'd12, 8'd34, 8'd56});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_shadow", {s_hour, s_min, s_sec}, 24'd0);
        chk("mid_rst_run", run_ena, 1'b1);
        chk("mid_rst_set", {set_hour, set_min, set_sec}, 3'b000);
        chk("mid_rst_field", edit_field, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b1, 1'b0);
        chk("run_inc_ignored", {s_hour, s_min, s_sec}, 24'd0);
        press(1'b0, 1'b0, 1'b1);
        chk("run_dec_ignored", {s_hour, s_min, s_sec}, 24'd0);
        chk("run_field", edit_field, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-panel time-setting controller for the digital clock, and the initiator of the counters' set/load interface. It debounces three raw push-buttons and steps through hour, minute and second edit modes. It keeps editable shadow copies of the time and drives the load-value buses plus one-cycle set pulses into the hour (mod-24) and minute/second (mod-60) counters. It also gates the counters' count enable while editing is in progress.

Parameters:
DEB_CYCLES, 500000, clock cycles a synchronized key level must differ stably before the debounced level flips (10 ms at 50 MHz); must be >= 2.
TIMEOUT_CYCLES, 500000000, idle cycles in any edit state before the edit is abandoned without commit; must be >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_mode_n  in  1  raw mode button, active-low, asynchronous to clk
key_inc_n  in  1  raw increment button, active-low, asynchronous
key_dec_n  in  1  raw decrement button, active-low, asynchronous
cur_hour  in  8  live hour value, binary 0..23
cur_min  in  8  live minute value, binary 0..59
cur_sec  in  8  live second value, binary 0..59
s_hour  out  8  hour load value (shadow register)
s_min  out  8  minute load value (shadow register)
s_sec  out  8  second load value (shadow register)
set_hour  out  1  one-cycle load strobe to the hour counter
set_min  out  1  one-cycle load strobe to the minute counter
set_sec  out  1  one-cycle load strobe to the second counter
run_ena  out  1  count-enable gate; 1 only in RUN
edit_field  out  2  0 = none, 1 = hour, 2 = minute, 3 = second (drives display blink)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state RUN, shadows 0, set_* 0, run_ena 1, edit_field 0.
  - Synchronizers and debounced levels reset to 1 (released); debounce and timeout counters 0.
- Key path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - Counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DEB_CYCLES-1 while the levels still differ, the debounced level takes the synced level on that edge and the counter clears.
  - press event is a 1-cycle pulse on each debounced 1->0 transition. Releases produce no event.
  - Glitches shorter than DEB_CYCLES cycles are ignored.
- FSM states: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
  - RUN, on mode press: capture cur_* into the shadows, go to EDIT_H. Any captured value above the field maximum loads as 0.
  - EDIT_H -> EDIT_M -> EDIT_S, each on a mode press.
  - EDIT_S, on mode press: go to COMMIT.
  - COMMIT lasts exactly 1 cycle: set_hour, set_min and set_sec all 1 with the shadows stable, then return to RUN.
  - In RUN, inc and dec presses are ignored and the shadows hold.
- Field arithmetic (edit states, on the selected shadow only):
  - inc: max -> 0, else +1. Maximum is 23 for hour, 59 for min/sec.
  - dec: 0 -> max, else -1.
  - The result is registered on the same edge the event is seen.
- Simultaneous events in the same cycle:
  - mode wins; inc/dec are discarded.
  - inc and dec together with no mode: no change, but the timeout counter still reloads.
- Timeout:
  - The counter clears on entry to EDIT_H and on any press event while in an edit state; it increments every other edit-state cycle.
  - Reaching TIMEOUT_CYCLES-1 sends the FSM to RUN with no set pulses.
  - The shadows keep the abandoned values; this is harmless because no strobe is issued.
- Outputs:
  - run_ena = 0 in EDIT_H, EDIT_M, EDIT_S and COMMIT; 1 in RUN.
  - edit_field follows the state; COMMIT reports 0.
  - s_* are always driven from the shadows.
  - set_* are never asserted outside COMMIT.
- Reset mid-edit: immediate return to the reset state; no strobe is issued.
- All state is registered; no combinational path from key inputs to any output.

Test Plan:
Bench parameters: DEB_CYCLES=4, TIMEOUT_CYCLES=64.
1. Debounce: key_inc_n low for 3 cycles, then high -> no event. key_mode_n held low -> EDIT_H entered exactly DEB_CYCLES+2 edges after the first sampled low. run_ena falls with that entry.
2. Edit wrap: cur_hour=23, cur_min=0, cur_sec=59; enter edit, inc once -> s_hour 0. Mode, dec once -> s_min 59. Mode, inc once -> s_sec 0.
3. Commit: from EDIT_S, mode press -> exactly one cycle with set_hour=set_min=set_sec=1 and s_hour=0, s_min=59, s_sec=0. Next cycle: run_ena=1, edit_field=0.
4. Timeout: enter EDIT_M, no keys for 64 cycles -> return to RUN, zero set_* pulses, run_ena=1.
5. Simultaneous events: mode and inc debounced on the same cycle in EDIT_H -> advance to EDIT_M, s_hour unchanged. inc+dec together in EDIT_M -> s_min unchanged.
6. Reset and RUN checks: assert rst_n low while in EDIT_S with shadows 12/34/56 -> outputs immediately s_*=0, run_ena=1, set_*=0. Inc presses in RUN -> no shadow change.
